// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - base core operator encodings used by the EX-stage ALU
package ibex_pkg;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ZPN_INSTR
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_OP_MULL,
        MD_OP_MULH,
        MD_OP_DIV,
        MD_OP_REM
    } md_op_e;

endpackage

// File: rtl/ibex_pkg_pext.sv
// rtl/ibex_pkg_pext.sv - packed-SIMD operation encodings
package ibex_pkg_pext;

    typedef enum logic [4:0] {
        ZPN_ADD16,
        ZPN_SUB16,
        ZPN_RADD16,
        ZPN_KADD16,
        ZPN_KSUB16,
        ZPN_SRA16,
        ZPN_SRL16,
        ZPN_SLL16,
        ZPN_SCLIP16,
        ZPN_UCLIP16,
        ZPN_ADD8,
        ZPN_SUB8,
        ZPN_KADD8,
        ZPN_SMMUL,
        ZPN_KMMAC,
        ZPN_KMMSB
    } zpn_op_e;

endpackage

// File: rtl/ibex_pext_alu.sv
// rtl/ibex_pext_alu.sv - packed-SIMD ALU with shared 4-quadrant 32x32 multiplier
module ibex_pext_alu
    import ibex_pkg::*;
    import ibex_pkg_pext::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  zpn_op_e              zpn_operator_i,
    input  alu_op_e              alu_operator_i,
    input  md_op_e               multdiv_operator_i,
    input  logic                 multdiv_sel_i,
    input  logic                 mult_en_i,
    input  logic                 div_en_i,
    input  logic                 mult_sel_i,
    input  logic                 div_sel_i,
    input  logic [1:0]           signed_mode_i,
    input  logic                 multdiv_ready_id_i,
    input  logic                 data_ind_timing_i,
    input  logic [33:0]          imd_val_q_i [2],
    output logic [33:0]          imd_val_d_o [2],
    output logic [1:0]           imd_val_we_o,
    input  logic [31:0]          operand_a_i,
    input  logic [31:0]          operand_b_i,
    input  logic [31:0]          operand_rd_i,
    input  logic [4:0]           imm_val_i,
    output logic [31:0]          adder_result_o,
    output logic [31:0]          result_o,
    output logic                 valid_o,
    output logic                 set_ov_o,
    output logic                 comparison_result_o
);

    logic        unused_inputs;
    logic [1:0]  quad_q;
    logic        is_zpn, zpn_mul, div_op, md_mul, mul_op, a_signed, b_signed;
    logic [16:0] mul_a, mul_b;
    logic signed [33:0] mul_p;
    logic [63:0] prod;
    logic [31:0] prod_hi, acc_sat;
    logic [32:0] acc;
    logic        acc_ov;
    logic [31:0] simd_res;
    logic        simd_ov;
    logic [15:0] h_a, h_b, h_r;
    logic [16:0] s17, d17;
    logic signed [16:0] x17, lim, hi_b, lo_b;
    logic [7:0]  b_a, b_b;
    logic [8:0]  s9, d9;

    assign unused_inputs = ^{multdiv_ready_id_i, data_ind_timing_i, mult_sel_i,
                             imm_val_i[4], imd_val_q_i[0][33:32]};

    assign adder_result_o      = operand_a_i + operand_b_i;
    assign comparison_result_o = (operand_a_i == operand_b_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quad_q <= 2'd0;
        end else if (mult_en_i) begin
            quad_q <= quad_q + 2'd1;
        end else begin
            quad_q <= 2'd0;
        end
    end

    assign is_zpn  = (alu_operator_i == ZPN_INSTR);
    assign zpn_mul = is_zpn && (zpn_operator_i inside {ZPN_SMMUL, ZPN_KMMAC, ZPN_KMMSB});
    assign div_op  = !is_zpn && (div_sel_i || div_en_i ||
                     (multdiv_sel_i && (multdiv_operator_i inside {MD_OP_DIV, MD_OP_REM})));
    assign md_mul  = !is_zpn && multdiv_sel_i && !div_op;
    assign mul_op  = zpn_mul || md_mul;
    assign a_signed = zpn_mul || signed_mode_i[0];
    assign b_signed = zpn_mul || signed_mode_i[1];

    // Low halves are always unsigned; high halves carry the operand sign only when signed.
    always_comb begin
        mul_a = {1'b0, operand_a_i[15:0]};
        mul_b = {1'b0, operand_b_i[15:0]};
        case (quad_q)
            2'd1:    mul_b = {b_signed & operand_b_i[31], operand_b_i[31:16]};
            2'd2:    mul_a = {a_signed & operand_a_i[31], operand_a_i[31:16]};
            2'd3: begin
                mul_a = {a_signed & operand_a_i[31], operand_a_i[31:16]};
                mul_b = {b_signed & operand_b_i[31], operand_b_i[31:16]};
            end
            default: ;
        endcase
    end

    assign mul_p = $signed(mul_a) * $signed(mul_b);

    // imd[1] accumulates both cross terms plus the carry out of the low partial product.
    always_comb begin
        imd_val_d_o[0] = imd_val_q_i[0];
        imd_val_d_o[1] = imd_val_q_i[1];
        case (quad_q)
            2'd0:    imd_val_d_o[0] = mul_p;
            2'd1:    imd_val_d_o[1] = mul_p;
            2'd2:    imd_val_d_o[1] = imd_val_q_i[1] + mul_p + {18'b0, imd_val_q_i[0][31:16]};
            default: ;
        endcase
        imd_val_we_o = (mul_op && quad_q != 2'd3) ? 2'b11 : 2'b00;
    end

    assign prod = {mul_p[31:0], 32'b0}
                + {{14{imd_val_q_i[1][33]}}, imd_val_q_i[1], 16'b0}
                + {48'b0, imd_val_q_i[0][15:0]};
    assign prod_hi = prod[63:32];

    assign acc     = (zpn_operator_i == ZPN_KMMSB) ? {operand_rd_i[31], operand_rd_i} - {prod_hi[31], prod_hi}
                                                   : {operand_rd_i[31], operand_rd_i} + {prod_hi[31], prod_hi};
    assign acc_ov  = acc[32] ^ acc[31];
    assign acc_sat = acc_ov ? (acc[32] ? 32'h8000_0000 : 32'h7fff_ffff) : acc[31:0];

    always_comb begin
        simd_res = '0;
        simd_ov  = 1'b0;
        h_a = '0; h_b = '0; h_r = '0; s17 = '0; d17 = '0; x17 = '0;
        b_a = '0; b_b = '0; s9 = '0; d9 = '0;
        lim  = 17'sd1 <<< imm_val_i[3:0];
        hi_b = lim - 17'sd1;
        lo_b = -lim;
        for (int i = 0; i < 2; i++) begin
            h_a = operand_a_i[16*i +: 16];
            h_b = operand_b_i[16*i +: 16];
            s17 = {h_a[15], h_a} + {h_b[15], h_b};
            d17 = {h_a[15], h_a} - {h_b[15], h_b};
            x17 = $signed({h_a[15], h_a});
            h_r = 16'h0;
            case (zpn_operator_i)
                ZPN_ADD16:  h_r = s17[15:0];
                ZPN_SUB16:  h_r = d17[15:0];
                ZPN_RADD16: h_r = s17[16:1];
                ZPN_KADD16: begin
                    h_r = s17[15:0];
                    if (s17[16] != s17[15]) begin
                        h_r = s17[16] ? 16'h8000 : 16'h7fff;
                        simd_ov = 1'b1;
                    end
                end
                ZPN_KSUB16: begin
                    h_r = d17[15:0];
                    if (d17[16] != d17[15]) begin
                        h_r = d17[16] ? 16'h8000 : 16'h7fff;
                        simd_ov = 1'b1;
                    end
                end
                ZPN_SRA16:  h_r = $signed(h_a) >>> imm_val_i[3:0];
                ZPN_SRL16:  h_r = h_a >> imm_val_i[3:0];
                ZPN_SLL16:  h_r = h_a << imm_val_i[3:0];
                ZPN_SCLIP16: begin
                    h_r = h_a;
                    if (x17 > hi_b) begin
                        h_r = hi_b[15:0];
                        simd_ov = 1'b1;
                    end else if (x17 < lo_b) begin
                        h_r = lo_b[15:0];
                        simd_ov = 1'b1;
                    end
                end
                ZPN_UCLIP16: begin
                    h_r = h_a;
                    if (x17 > hi_b) begin
                        h_r = hi_b[15:0];
                        simd_ov = 1'b1;
                    end else if (x17 < 17'sd0) begin
                        h_r = 16'h0;
                        simd_ov = 1'b1;
                    end
                end
                default: h_r = 16'h0;
            endcase
            simd_res[16*i +: 16] = h_r;
        end
        for (int j = 0; j < 4; j++) begin
            b_a = operand_a_i[8*j +: 8];
            b_b = operand_b_i[8*j +: 8];
            s9  = {b_a[7], b_a} + {b_b[7], b_b};
            d9  = {b_a[7], b_a} - {b_b[7], b_b};
            case (zpn_operator_i)
                ZPN_ADD8: simd_res[8*j +: 8] = s9[7:0];
                ZPN_SUB8: simd_res[8*j +: 8] = d9[7:0];
                ZPN_KADD8: begin
                    simd_res[8*j +: 8] = s9[7:0];
                    if (s9[8] != s9[7]) begin
                        simd_res[8*j +: 8] = s9[8] ? 8'h80 : 8'h7f;
                        simd_ov = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        result_o = 32'h0;
        valid_o  = 1'b1;
        set_ov_o = 1'b0;
        if (mul_op) begin
            valid_o = (quad_q == 2'd3);
            if (zpn_mul) begin
                case (zpn_operator_i)
                    ZPN_KMMAC, ZPN_KMMSB: begin
                        result_o = acc_sat;
                        set_ov_o = valid_o & acc_ov;
                    end
                    default: result_o = prod_hi;
                endcase
            end else begin
                result_o = (multdiv_operator_i == MD_OP_MULL) ? prod[31:0] : prod_hi;
            end
        end else if (is_zpn) begin
            result_o = simd_res;
            set_ov_o = simd_ov;
        end
    end

endmodule

// File: tb/tb_ibex_pext_alu.sv
// tb/tb_ibex_pext_alu.sv - directed scoreboard bench for the packed-SIMD ALU
module tb_ibex_pext_alu;
    import ibex_pkg::*;
    import ibex_pkg_pext::*;

    logic        clk = 1'b0;
    logic        rst_n;
    zpn_op_e     zpn_op;
    alu_op_e     alu_op;
    md_op_e      md_op;
    logic        multdiv_sel, mult_en, div_en, mult_sel, div_sel;
    logic [1:0]  signed_mode;
    logic        md_ready, dit;
    logic [33:0] imd_q [2];
    logic [33:0] imd_d [2];
    logic [1:0]  imd_we;
    logic [31:0] a, b, rd;
    logic [4:0]  imm;
    logic [31:0] adder_res, result;
    logic        valid, set_ov, cmp_res;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        ov;
    } exp_t;

    exp_t scb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    ibex_pext_alu dut (
        .clk_i(clk), .rst_ni(rst_n), .zpn_operator_i(zpn_op), .alu_operator_i(alu_op),
        .multdiv_operator_i(md_op), .multdiv_sel_i(multdiv_sel), .mult_en_i(mult_en),
        .div_en_i(div_en), .mult_sel_i(mult_sel), .div_sel_i(div_sel),
        .signed_mode_i(signed_mode), .multdiv_ready_id_i(md_ready), .data_ind_timing_i(dit),
        .imd_val_q_i(imd_q), .imd_val_d_o(imd_d), .imd_val_we_o(imd_we),
        .operand_a_i(a), .operand_b_i(b), .operand_rd_i(rd), .imm_val_i(imm),
        .adder_result_o(adder_res), .result_o(result), .valid_o(valid),
        .set_ov_o(set_ov), .comparison_result_o(cmp_res)
    );

    always #5 clk = ~clk;

    // Stands in for the core's intermediate-value registers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imd_q[0] <= '0;
            imd_q[1] <= '0;
        end else begin
            if (imd_we[0]) imd_q[0] <= imd_d[0];
            if (imd_we[1]) imd_q[1] <= imd_d[1];
        end
    end

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (scb.size() == 0) begin
            check({tag, " scoreboard nonempty"}, 34'd0, 34'd1);
        end else begin
            e = scb.pop_front();
            check(e.tag, {2'b0, result}, {2'b0, e.res});
            check({e.tag, " ov"}, {33'b0, set_ov}, {33'b0, e.ov});
        end
    endtask

    task automatic single(input string tag, input alu_op_e aop, input zpn_op_e op,
                          input logic dsel, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [4:0] iimm, input logic [31:0] eres, input logic eov);
        @(posedge clk); #1;
        alu_op = aop; zpn_op = op; md_op = dsel ? MD_OP_DIV : MD_OP_MULL;
        multdiv_sel = dsel; div_sel = dsel; div_en = dsel; mult_en = 1'b0;
        a = ia; b = ib; imm = iimm;
        scb.push_back('{tag, eres, eov});
        #4;
        check({tag, " valid"}, {33'b0, valid}, 34'd1);
        pop_and_compare(tag);
    endtask

    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sx, input logic sy);
        logic signed [65:0] xe, ye, p;
        xe = sx ? {{34{x[31]}}, x} : {34'b0, x};
        ye = sy ? {{34{y[31]}}, y} : {34'b0, y};
        p  = xe * ye;
        return p[63:0];
    endfunction

    task automatic mul(input string tag, input alu_op_e aop, input zpn_op_e op, input md_op_e mop,
                       input logic [1:0] sm, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ird, input int ncyc);
        logic [63:0] p;
        logic [32:0] acc;
        logic [31:0] eres;
        logic        eov;
        eov = 1'b0;
        if (aop == ZPN_INSTR) begin
            p = mul64(ia, ib, 1'b1, 1'b1);
            eres = p[63:32];
            if (op != ZPN_SMMUL) begin
                acc = (op == ZPN_KMMSB) ? ({ird[31], ird} - {p[63], p[63:32]})
                                        : ({ird[31], ird} + {p[63], p[63:32]});
                if (acc > 33'sh0_7fff_ffff && !acc[32]) begin
                    eres = 32'h7fff_ffff; eov = 1'b1;
                end else if (acc[32] && acc[31:0] < 32'h8000_0000) begin
                    eres = 32'h8000_0000; eov = 1'b1;
                end else begin
                    eres = acc[31:0];
                end
            end
        end else begin
            p = mul64(ia, ib, sm[0], sm[1]);
            eres = (mop == MD_OP_MULL) ? p[31:0] : p[63:32];
        end
        for (int n = 0; n < ncyc / 4; n++) scb.push_back('{tag, eres, eov});
        @(posedge clk); #1;
        alu_op = aop; zpn_op = op; md_op = mop; signed_mode = sm;
        multdiv_sel = (aop != ZPN_INSTR); div_sel = 1'b0; div_en = 1'b0;
        a = ia; b = ib; rd = ird; mult_en = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            #4;
            check($sformatf("%s valid c%0d", tag, k), {33'b0, valid}, {33'b0, (k % 4 == 0)});
            check($sformatf("%s we c%0d", tag, k), {32'b0, imd_we}, (k % 4 == 0) ? 34'd0 : 34'd3);
            if (valid) pop_and_compare(tag);
            @(posedge clk); #1;
        end
        mult_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_op = ZPN_INSTR; zpn_op = ZPN_ADD16; md_op = MD_OP_MULL;
        multdiv_sel = 0; mult_en = 0; div_en = 0; mult_sel = 0; div_sel = 0;
        signed_mode = 2'b00; md_ready = 1'b1; dit = 1'b0;
        a = 32'h0000_0001; b = 32'h0000_0002; rd = '0; imm = '0;
        #2;
        check("reset add16 valid", {33'b0, valid}, 34'd1);
        check("reset add16 result", {2'b0, result}, 34'h0_0000_0003);
        zpn_op = ZPN_KMMAC;
        #1;
        check("reset mul valid", {33'b0, valid}, 34'd0);
        check("reset mul we", {32'b0, imd_we}, 34'd3);
        #9 rst_n = 1'b1;

        single("kadd16", ZPN_INSTR, ZPN_KADD16, 1'b0, 32'h7fff_8000, 32'h0001_ffff, 5'd0, 32'h7fff_8000, 1'b1);
        check("adder_result", {2'b0, adder_res}, 34'h0_8001_7fff);
        check("comparison ne", {33'b0, cmp_res}, 34'd0);
        single("add16", ZPN_INSTR, ZPN_ADD16, 1'b0, 32'h7fff_8000, 32'h0001_ffff, 5'd0, 32'h8000_7fff, 1'b0);
        single("sub16", ZPN_INSTR, ZPN_SUB16, 1'b0, 32'h0001_0000, 32'h0002_0001, 5'd0, 32'hffff_ffff, 1'b0);
        single("radd16 ext", ZPN_INSTR, ZPN_RADD16, 1'b0, 32'h7fff_8000, 32'h7fff_8000, 5'd0, 32'h7fff_8000, 1'b0);
        single("radd16 neg", ZPN_INSTR, ZPN_RADD16, 1'b0, 32'h0003_0005, 32'h0000_fff0, 5'd0, 32'h0001_fffa, 1'b0);
        single("ksub16", ZPN_INSTR, ZPN_KSUB16, 1'b0, 32'h8000_7fff, 32'h0001_ffff, 5'd0, 32'h8000_7fff, 1'b1);
        single("sra16", ZPN_INSTR, ZPN_SRA16, 1'b0, 32'h8000_f0f0, 32'h0, 5'h14, 32'hf800_ff0f, 1'b0);
        single("srl16", ZPN_INSTR, ZPN_SRL16, 1'b0, 32'h8000_f0f0, 32'h0, 5'h04, 32'h0800_0f0f, 1'b0);
        single("sll16", ZPN_INSTR, ZPN_SLL16, 1'b0, 32'h8001_f0f0, 32'h0, 5'h04, 32'h0010_0f00, 1'b0);
        single("sclip16 6", ZPN_INSTR, ZPN_SCLIP16, 1'b0, 32'h1545_ff80, 32'h0, 5'd6, 32'h003f_ffc0, 1'b1);
        single("sclip16 15", ZPN_INSTR, ZPN_SCLIP16, 1'b0, 32'h8000_7fff, 32'h0, 5'd15, 32'h8000_7fff, 1'b0);
        single("uclip16 6", ZPN_INSTR, ZPN_UCLIP16, 1'b0, 32'h0015_fff0, 32'h0, 5'd6, 32'h0015_0000, 1'b1);
        single("uclip16 0", ZPN_INSTR, ZPN_UCLIP16, 1'b0, 32'h0001_0000, 32'h0, 5'd0, 32'h0000_0000, 1'b1);
        single("add8", ZPN_INSTR, ZPN_ADD8, 1'b0, 32'h80ff_7f01, 32'h8001_7f01, 5'd0, 32'h0000_fe02, 1'b0);
        single("sub8", ZPN_INSTR, ZPN_SUB8, 1'b0, 32'h0001_0203, 32'h0101_0101, 5'd0, 32'hff00_0102, 1'b0);
        single("kadd8", ZPN_INSTR, ZPN_KADD8, 1'b0, 32'h80ff_7f01, 32'h8001_7f01, 5'd0, 32'h8000_7f02, 1'b1);
        single("unsupported", ZPN_INSTR, zpn_op_e'(5'd21), 1'b0, 32'h1234_5678, 32'h1234_5678, 5'd3, 32'h0, 1'b0);
        check("comparison eq", {33'b0, cmp_res}, 34'd1);
        single("div", ALU_ADD, ZPN_ADD16, 1'b1, 32'h0000_0064, 32'h0000_0005, 5'd0, 32'h0, 1'b0);

        mul("kmmsb", ZPN_INSTR, ZPN_KMMSB, MD_OP_MULL, 2'b00, 32'h1545_0015, 32'h5142_18d4, 32'hffff_ffff, 8);
        mul("kmmsb sat", ZPN_INSTR, ZPN_KMMSB, MD_OP_MULL, 2'b00, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 4);
        mul("kmmac sat", ZPN_INSTR, ZPN_KMMAC, MD_OP_MULL, 2'b00, 32'h4000_0000, 32'h4000_0000, 32'h7fff_ffff, 4);
        mul("smmul", ZPN_INSTR, ZPN_SMMUL, MD_OP_MULL, 2'b00, 32'hffff_ffff, 32'h0000_0002, 32'h0, 4);
        mul("mulh ss", ALU_ADD, ZPN_ADD16, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0, 4);
        mul("mulhu", ALU_ADD, ZPN_ADD16, MD_OP_MULH, 2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 4);
        mul("mulh su", ALU_ADD, ZPN_ADD16, MD_OP_MULH, 2'b01, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 4);
        mul("mull", ALU_ADD, ZPN_ADD16, MD_OP_MULL, 2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 4);

        // Abort a multiply in quadrant 2 with reset, then rerun it from scratch.
        @(posedge clk); #1;
        alu_op = ZPN_INSTR; zpn_op = ZPN_KMMAC; multdiv_sel = 1'b0;
        a = 32'h1545_0015; b = 32'h5142_18d4; rd = 32'h0000_1000; mult_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0; mult_en = 1'b0;
        #1;
        check("mid-reset valid", {33'b0, valid}, 34'd0);
        check("mid-reset quad0 imd", imd_d[0], {18'b0, a[15:0]} * {18'b0, b[15:0]});
        #1 rst_n = 1'b1;
        mul("post-reset kmmac", ZPN_INSTR, ZPN_KMMAC, MD_OP_MULL, 2'b00, 32'h1545_0015, 32'h5142_18d4, 32'h0000_1000, 4);

        check("scoreboard drained", scb.size(), 34'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
